// File: rtl/wash_phase_timer.sv
// Phase-duration timer for the wash-cycle controller: prescaled tick down-counter with pause/abort.
// Optional WPT_HEAVY_LOAD_EN adds a `heavy` input that doubles SOAK/WASH durations (saturating).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | timer disabled, counters cleared
//   S_RUN   | counting prescaler ticks, remaining decrements per tick
//   S_PAUSE | lid open, prescaler and remaining frozen
//   S_DONE  | duration expired, waiting for phase change or disable
module wash_phase_timer #(
   parameter int TICK_DIV    = 1000,
   parameter int CNT_W       = 16,
   parameter int SOAK_TICKS  = 10,
   parameter int WASH_TICKS  = 20,
   parameter int RINSE_TICKS = 15,
   parameter int SPIN_TICKS  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             timer_enable,
   input  logic [1:0]       phase_sel,
   input  logic             pause,
`ifdef WPT_HEAVY_LOAD_EN
   input  logic             heavy,
`endif
   output logic             timer_done,
   output logic [CNT_W-1:0] remaining,
   output logic             running
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [1:0]       phase_q, phase_d;
   logic             done_q, done_d;

   logic heavy_i;
   logic load, counting, tick, expire;

`ifdef WPT_HEAVY_LOAD_EN
   assign heavy_i = heavy;
`else
   assign heavy_i = 1'b0;
`endif

   // A zero duration loads as one so every phase produces exactly one done pulse.
   function automatic logic [CNT_W-1:0] load_value(input logic [1:0] ph, input logic hv);
      logic [CNT_W-1:0] base;
      logic [CNT_W:0]   dbl;
      case (ph)
         2'b00:   base = CNT_W'(SOAK_TICKS);
         2'b01:   base = CNT_W'(WASH_TICKS);
         2'b10:   base = CNT_W'(RINSE_TICKS);
         default: base = CNT_W'(SPIN_TICKS);
      endcase
      if (base == '0) base = CNT_W'(1);
      dbl = {base, 1'b0};
      if (hv && !ph[1]) return dbl[CNT_W] ? '1 : dbl[CNT_W-1:0];
      return base;
   endfunction

   // Priority: disable, then phase change (or entry from idle), then pause, then tick.
   // Leaving PAUSE counts as a run cycle, so a pause of N cycles delays done by exactly N.
   assign load     = timer_enable && ((state_q == S_IDLE) || (phase_sel != phase_q));
   assign counting = timer_enable && !load && !pause &&
                     ((state_q == S_RUN) || (state_q == S_PAUSE));
   assign tick     = counting && (presc_q == PRESC_MAX);
   assign expire   = tick && (rem_q == CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!timer_enable)
         state_d = S_IDLE;
      else if (load)
         state_d = S_RUN;
      else if (expire)
         state_d = S_DONE;
      else if ((state_q == S_RUN) || (state_q == S_PAUSE))
         state_d = pause ? S_PAUSE : S_RUN;
   end

   always_comb begin
      running    = (state_q == S_RUN);
      timer_done = done_q;
      remaining  = rem_q;
   end

   always_comb begin
      presc_d = presc_q;
      rem_d   = rem_q;
      phase_d = phase_q;
      done_d  = 1'b0;
      if (!timer_enable) begin
         presc_d = '0;
         rem_d   = '0;
      end else if (load) begin
         presc_d = '0;
         rem_d   = load_value(phase_sel, heavy_i);
         phase_d = phase_sel;
      end else if (counting) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         if (tick && (rem_q != '0)) rem_d = rem_q - CNT_W'(1);
         done_d  = expire;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         rem_q   <= '0;
         phase_q <= 2'b00;
         done_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         rem_q   <= rem_d;
         phase_q <= phase_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_wash_phase_timer.sv
// Self-checking bench for wash_phase_timer: directed scenarios then random stimulus against
// an elapsed-cycle reference model. Define WPT_HEAVY_LOAD_EN to also exercise the heavy load.
module tb_wash_phase_timer;

   localparam int TD    = 4;
   localparam int CW    = 8;
   localparam int SOAK  = 3;
   localparam int WASH  = 5;
   localparam int RINSE = 2;
   localparam int SPIN  = 2;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic [1:0]    ps;
   logic          pz;
   logic          hv;
   logic          timer_done;
   logic [CW-1:0] remaining;
   logic          running;

   int errors = 0;
   int checks = 0;
   int cnum   = 0;
   int t0     = 0;
   int at;

   // reference model: mode 0 idle, 1 running, 2 paused, 3 done; e = counted run cycles
   int m_mode, m_phase, m_n, m_e, m_done;

   wash_phase_timer #(
      .TICK_DIV(TD), .CNT_W(CW), .SOAK_TICKS(SOAK), .WASH_TICKS(WASH),
      .RINSE_TICKS(RINSE), .SPIN_TICKS(SPIN)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .timer_enable(en), .phase_sel(ps), .pause(pz),
`ifdef WPT_HEAVY_LOAD_EN
      .heavy(hv),
`endif
      .timer_done(timer_done), .remaining(remaining), .running(running)
   );

`ifdef WPT_HEAVY_LOAD_EN
   logic          done_sat;
   logic [CW-1:0] rem_sat;
   logic          run_sat;
   wash_phase_timer #(
      .TICK_DIV(TD), .CNT_W(CW), .SOAK_TICKS(200), .WASH_TICKS(WASH),
      .RINSE_TICKS(RINSE), .SPIN_TICKS(SPIN)
   ) u_dut_sat (
      .clk(clk), .rst_n(rst_n), .timer_enable(en), .phase_sel(ps), .pause(pz),
      .heavy(hv), .timer_done(done_sat), .remaining(rem_sat), .running(run_sat)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int m_dur(input int ph, input logic h);
      int d;
      case (ph)
         0:       d = SOAK;
         1:       d = WASH;
         2:       d = RINSE;
         default: d = SPIN;
      endcase
      if (d == 0) d = 1;
      if (h && ph < 2) begin
         d = d * 2;
         if (d > (1 << CW) - 1) d = (1 << CW) - 1;
      end
      return d;
   endfunction

   function automatic int m_rem();
      return (m_mode == 0) ? 0 : m_n - m_e / TD;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_phase = 0; m_n = 0; m_e = 0; m_done = 0;
   endtask

   task automatic model_step();
      m_done = 0;
      if (!en) begin
         m_mode = 0; m_n = 0; m_e = 0;
      end else if (m_mode == 0 || int'(ps) != m_phase) begin
         m_phase = int'(ps); m_n = m_dur(int'(ps), hv); m_e = 0; m_mode = 1;
      end else if (m_mode == 3) begin
         m_done = 0;
      end else if (pz) begin
         m_mode = 2;
      end else begin
         m_e++;
         m_mode = 1;
         if (m_e == m_n * TD) begin
            m_mode = 3; m_done = 1;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      cnum++;
      if (!rst_n) model_reset();
      else        model_step();
      #1;
      chk("remaining", 32'(remaining), 32'(m_rem()));
      chk("timer_done", 32'(timer_done), 32'(m_done));
      chk("running", 32'(running), (m_mode == 1) ? 32'd1 : 32'd0);
   endtask

   task automatic wait_done(input int budget, output int when);
      when = -1;
      for (int i = 0; i < budget; i++) begin
         cyc();
         if (timer_done === 1'b1) begin
            when = cnum - t0;
            break;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; ps = 2'b00; pz = 1'b0; hv = 1'b0;
      model_reset();
      #3;
      chk("rst_remaining", 32'(remaining), 32'd0);
      chk("rst_done", 32'(timer_done), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      cyc(); cyc();
      rst_n = 1'b1;
      cyc(); cyc();

      // nominal SOAK followed by the full controller sequence
      en = 1'b1; ps = 2'b00;
      cyc(); t0 = cnum;
      chk("soak_load", 32'(remaining), 32'd3);
      wait_done(20, at);  chk("soak_done_at", at, 12);
      ps = 2'b01; cyc();
      chk("wash_load", 32'(remaining), 32'd5);
      wait_done(30, at);  chk("wash_done_at", at, 33);
      ps = 2'b10; cyc();
      wait_done(20, at);  chk("rinse_done_at", at, 42);
      ps = 2'b11; cyc();
      wait_done(20, at);  chk("spin_done_at", at, 51);
      cyc(); cyc(); cyc();
      en = 1'b0; cyc();
      chk("final_idle_remaining", 32'(remaining), 32'd0);
      chk("final_idle_running", 32'(running), 32'd0);

      // pause in WASH with remaining=3 for 10 cycles
      en = 1'b1; ps = 2'b01;
      cyc(); t0 = cnum;
      for (int i = 0; i < 9; i++) cyc();
      chk("pre_pause_remaining", 32'(remaining), 32'd3);
      pz = 1'b1;
      for (int i = 0; i < 10; i++) cyc();
      chk("pause_frozen", 32'(remaining), 32'd3);
      chk("pause_running", 32'(running), 32'd0);
      pz = 1'b0;
      wait_done(30, at);  chk("pause_done_at", at, 30);
      en = 1'b0; cyc();

      // abort coincident with the final tick
      en = 1'b1; ps = 2'b00;
      cyc();
      for (int i = 0; i < 11; i++) cyc();
      chk("pre_abort_remaining", 32'(remaining), 32'd1);
      en = 1'b0; cyc();
      chk("abort_no_done", 32'(timer_done), 32'd0);
      chk("abort_remaining", 32'(remaining), 32'd0);
      chk("abort_running", 32'(running), 32'd0);
      cyc(); cyc();

      // asynchronous reset in the middle of RUN
      en = 1'b1; ps = 2'b10;
      cyc(); cyc(); cyc(); cyc();
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_rst_remaining", 32'(remaining), 32'd0);
      chk("async_rst_running", 32'(running), 32'd0);
      chk("async_rst_done", 32'(timer_done), 32'd0);
      en = 1'b0;
      cyc(); cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) cyc();
      en = 1'b1; ps = 2'b10; cyc();
      chk("post_rst_load", 32'(remaining), 32'd2);
      en = 1'b0; cyc();

`ifdef WPT_HEAVY_LOAD_EN
      hv = 1'b1; en = 1'b1; ps = 2'b01; cyc();
      chk("heavy_wash_load", 32'(remaining), 32'd10);
      en = 1'b0; cyc();
      en = 1'b1; ps = 2'b00; cyc();
      chk("heavy_soak_load", 32'(remaining), 32'd6);
      chk("heavy_soak_saturate", 32'(rem_sat), 32'd255);
      en = 1'b0; hv = 1'b0; cyc();
`endif

      // random traffic; controller advances phase after each done pulse
      for (int i = 0; i < 3000; i++) begin
         en = ($urandom_range(0, 39) != 0);
         pz = ($urandom_range(0, 7) == 0);
         if (timer_done === 1'b1) ps = ps + 2'd1;
         else if ($urandom_range(0, 63) == 0) ps = 2'($urandom_range(0, 3));
`ifdef WPT_HEAVY_LOAD_EN
         hv = 1'($urandom_range(0, 1));
`endif
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
